// File: rtl/axi_burst_pkg.sv
// Shared AXI burst definitions: burst-type encodings, FSM state type and
// a helper that tells whether a WRAP length is legal (2, 4, 8 or 16 beats).
package axi_burst_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic {
      IDLE,
      BURST
   } state_e;

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) ||
             (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_burst_addr_next.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Ports: addr_i (current beat address), len_i, size_i, burst_i -> addr_next_o.
module axi_burst_addr_next
   import axi_burst_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [7:0]            len_i,
   input  logic [2:0]            size_i,
   input  logic [1:0]            burst_i,
   output logic [ADDR_WIDTH-1:0] addr_next_o
);

   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] bytes;
   logic [ADDR_WIDTH-1:0] wrap_bytes;
   logic [ADDR_WIDTH-1:0] wrap_mask;
   logic [ADDR_WIDTH-1:0] incr;

   always_comb begin
      bytes       = ONE << size_i;
      wrap_bytes  = ADDR_WIDTH'({1'b0, len_i} + 9'd1) << size_i;
      wrap_mask   = wrap_bytes - ONE;
      incr        = (addr_i & ~(bytes - ONE)) + bytes;
      addr_next_o = incr;
      if (burst_i == BURST_FIXED) begin
         addr_next_o = addr_i;
      end else if ((burst_i == BURST_WRAP) && wrap_len_ok(len_i)) begin
         // Window base comes from the current address: every beat of a
         // wrap burst sits inside the same aligned window, so masking the
         // incremented offset folds a carry out of the window back to base.
         addr_next_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
      end
   end

endmodule

// File: rtl/axi_aw_burst_gen.sv
// Expands one AXI AW request into a stream of per-beat addresses.
// Ports: slave_* AW handshake in, beat_* per-beat handshake/fields out.
module axi_aw_burst_gen
   import axi_burst_pkg::*;
#(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int USER_WIDTH = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  slave_valid_i,
   output logic                  slave_ready_o,
   input  logic [ADDR_WIDTH-1:0] slave_addr_i,
   input  logic [7:0]            slave_len_i,
   input  logic [2:0]            slave_size_i,
   input  logic [1:0]            slave_burst_i,
   input  logic [ID_WIDTH-1:0]   slave_id_i,
   input  logic [USER_WIDTH-1:0] slave_user_i,
   output logic                  beat_valid_o,
   input  logic                  beat_ready_i,
   output logic [ADDR_WIDTH-1:0] beat_addr_o,
   output logic [ID_WIDTH-1:0]   beat_id_o,
   output logic [USER_WIDTH-1:0] beat_user_o,
   output logic [2:0]            beat_size_o,
   output logic                  beat_last_o,
   output logic [7:0]            beat_idx_o
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [2:0]            size_q, size_d;
   logic [1:0]            burst_q, burst_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [USER_WIDTH-1:0] user_q, user_d;
   logic [7:0]            idx_q, idx_d;

   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic                  in_burst;
   logic                  beat_hs;
   logic                  aw_hs;

   axi_burst_addr_next #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_next (
      .addr_i      (addr_q),
      .len_i       (len_q),
      .size_i      (size_q),
      .burst_i     (burst_q),
      .addr_next_o (addr_nxt)
   );

   assign in_burst      = (state_q == BURST);
   assign beat_valid_o  = in_burst;
   // Gated by state so an idle/reset block never shows last (idx==len==0).
   assign beat_last_o   = in_burst && (idx_q == len_q);
   assign beat_hs       = beat_valid_o && beat_ready_i;
   assign slave_ready_o = !in_burst || (beat_hs && beat_last_o);
   assign aw_hs         = slave_valid_i && slave_ready_o;

   assign beat_addr_o = addr_q;
   assign beat_id_o   = id_q;
   assign beat_user_o = user_q;
   assign beat_size_o = size_q;
   assign beat_idx_o  = idx_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      size_d  = size_q;
      burst_d = burst_q;
      id_d    = id_q;
      user_d  = user_q;
      idx_d   = idx_q;
      if (beat_hs) begin
         if (beat_last_o) begin
            state_d = IDLE;
         end else begin
            idx_d  = idx_q + 8'd1;
            addr_d = addr_nxt;
         end
      end
      // A new AW overrides the return to IDLE for zero-bubble bursts.
      if (aw_hs) begin
         state_d = BURST;
         addr_d  = slave_addr_i;
         len_d   = slave_len_i;
         size_d  = slave_size_i;
         burst_d = slave_burst_i;
         id_d    = slave_id_i;
         user_d  = slave_user_i;
         idx_d   = 8'd0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         id_q    <= '0;
         user_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         id_q    <= id_d;
         user_q  <= user_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_axi_aw_burst_gen.sv
// Bench for axi_aw_burst_gen: directed AXI cases plus random bursts,
// checked each cycle against a closed-form queue model of expected beats.
module tb_axi_aw_burst_gen;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        slave_valid_i = 1'b0;
   logic        slave_ready_o;
   logic [31:0] slave_addr_i = '0;
   logic [7:0]  slave_len_i = '0;
   logic [2:0]  slave_size_i = '0;
   logic [1:0]  slave_burst_i = '0;
   logic [3:0]  slave_id_i = '0;
   logic [0:0]  slave_user_i = '0;
   logic        beat_valid_o;
   logic        beat_ready_i = 1'b1;
   logic [31:0] beat_addr_o;
   logic [3:0]  beat_id_o;
   logic [0:0]  beat_user_o;
   logic [2:0]  beat_size_o;
   logic        beat_last_o;
   logic [7:0]  beat_idx_o;

   axi_aw_burst_gen dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .slave_valid_i (slave_valid_i),
      .slave_ready_o (slave_ready_o),
      .slave_addr_i  (slave_addr_i),
      .slave_len_i   (slave_len_i),
      .slave_size_i  (slave_size_i),
      .slave_burst_i (slave_burst_i),
      .slave_id_i    (slave_id_i),
      .slave_user_i  (slave_user_i),
      .beat_valid_o  (beat_valid_o),
      .beat_ready_i  (beat_ready_i),
      .beat_addr_o   (beat_addr_o),
      .beat_id_o     (beat_id_o),
      .beat_user_o   (beat_user_o),
      .beat_size_o   (beat_size_o),
      .beat_last_o   (beat_last_o),
      .beat_idx_o    (beat_idx_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  idx;
      logic        last;
      logic [3:0]  id;
      logic [0:0]  user;
      logic [2:0]  size;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] obs_addr[$];
   logic [31:0] obs_idx[$];
   logic [31:0] exp_list[$];
   int          n_chk = 0;
   int          n_err = 0;
   logic        rst_prev = 1'b1;
   logic        rnd_mode = 1'b0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
      end
   endtask

   // Address of beat n from the AXI closed-form rules.
   function automatic logic [31:0] model_addr(input logic [31:0] start,
      input logic [7:0] len, input logic [2:0] size,
      input logic [1:0] burst, input int n);
      logic [31:0] bytes, total, aligned, base;
      logic        wrap;
      bytes   = 32'd1 << size;
      total   = bytes * (32'(len) + 32'd1);
      aligned = start & ~(bytes - 32'd1);
      wrap    = (burst == 2'b10) &&
                (len == 1 || len == 3 || len == 7 || len == 15);
      if (burst == 2'b00 || n == 0) return start;
      if (!wrap) return aligned + bytes * 32'(n);
      base = start & ~(total - 32'd1);
      return base + ((aligned - base + bytes * 32'(n)) % total);
   endfunction

   // Compare process: one check set per cycle, then advance the model.
   initial begin
      logic  ev, er;
      beat_t b;
      forever begin
         @(negedge clk_i);
         ev = (exp_q.size() != 0);
         er = !ev || (exp_q[0].last && beat_ready_i);
         check("slave_ready", 64'(slave_ready_o), 64'(er));
         check("beat_valid", 64'(beat_valid_o), 64'(ev));
         if (ev) begin
            check("beat_addr", 64'(beat_addr_o), 64'(exp_q[0].addr));
            check("beat_idx", 64'(beat_idx_o), 64'(exp_q[0].idx));
            check("beat_last", 64'(beat_last_o), 64'(exp_q[0].last));
            check("beat_id", 64'(beat_id_o), 64'(exp_q[0].id));
            check("beat_user", 64'(beat_user_o), 64'(exp_q[0].user));
            check("beat_size", 64'(beat_size_o), 64'(exp_q[0].size));
         end
         if (rst_prev) begin
            check("rst_zero", {beat_addr_o, 8'(beat_idx_o), 4'(beat_id_o),
                  1'(beat_user_o), 3'(beat_size_o), 1'(beat_last_o)}, 64'd0);
         end
         rst_prev = rst_i;
         if (rst_i) begin
            exp_q.delete();
         end else begin
            if (ev && beat_ready_i) begin
               obs_addr.push_back(beat_addr_o);
               obs_idx.push_back(32'(beat_idx_o));
               void'(exp_q.pop_front());
            end
            if (slave_valid_i && er) begin
               for (int n = 0; n <= int'(slave_len_i); n++) begin
                  b.addr = model_addr(slave_addr_i, slave_len_i,
                                      slave_size_i, slave_burst_i, n);
                  b.idx  = 8'(n);
                  b.last = (n == int'(slave_len_i));
                  b.id   = slave_id_i;
                  b.user = slave_user_i;
                  b.size = slave_size_i;
                  exp_q.push_back(b);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
      if (rnd_mode) beat_ready_i = ($urandom_range(0, 3) != 0);
   endtask

   task automatic aw(input logic [31:0] a, input logic [7:0] l,
                     input logic [2:0] s, input logic [1:0] bt,
                     input logic [3:0] id, input logic u);
      logic acc;
      int   k;
      slave_valid_i = 1'b1;
      slave_addr_i  = a;
      slave_len_i   = l;
      slave_size_i  = s;
      slave_burst_i = bt;
      slave_id_i    = id;
      slave_user_i  = u;
      acc = 1'b0;
      k   = 0;
      while (!acc && k < 2000) begin
         @(negedge clk_i);
         acc = slave_ready_o;
         tick();
         k++;
      end
      if (!acc) begin
         n_chk++;
         n_err++;
         $display("FAIL aw_timeout: no accept after %0d cycles", k);
      end
      slave_valid_i = 1'b0;
   endtask

   task automatic drain();
      int k;
      beat_ready_i = 1'b1;
      k = 0;
      while (exp_q.size() != 0 && k < 600) begin
         tick();
         k++;
      end
      if (exp_q.size() != 0) begin
         n_chk++;
         n_err++;
         $display("FAIL drain_timeout: %0d beats left", exp_q.size());
      end
      tick();
   endtask

   task automatic check_addr_log(input string name);
      check({name, "_count"}, 64'(obs_addr.size()), 64'(exp_list.size()));
      foreach (exp_list[i])
         if (i < obs_addr.size())
            check(name, 64'(obs_addr[i]), 64'(exp_list[i]));
   endtask

   task automatic check_idx_log(input string name);
      check({name, "_count"}, 64'(obs_idx.size()), 64'(exp_list.size()));
      foreach (exp_list[i])
         if (i < obs_idx.size())
            check(name, 64'(obs_idx[i]), 64'(exp_list[i]));
   endtask

   initial begin
      check("pin_incr", 64'(model_addr(32'h1003, 3, 2, 2'b01, 1)), 64'h1004);
      check("pin_wrap", 64'(model_addr(32'h1038, 3, 3, 2'b10, 1)), 64'h1020);
      check("pin_wrap3", 64'(model_addr(32'h1038, 3, 3, 2'b10, 3)), 64'h1030);
      check("pin_top", 64'(model_addr(32'hFFFFFFFC, 1, 2, 2'b01, 1)), 64'h0);

      tick();
      tick();
      rst_i = 1'b0;
      tick();

      obs_addr.delete();
      aw(32'h1003, 8'd3, 3'd2, 2'b01, 4'h5, 1'b1);
      drain();
      exp_list = {32'h1003, 32'h1004, 32'h1008, 32'h100C};
      check_addr_log("incr_addr");

      obs_addr.delete();
      aw(32'h1038, 8'd3, 3'd3, 2'b10, 4'hA, 1'b0);
      drain();
      exp_list = {32'h1038, 32'h1020, 32'h1028, 32'h1030};
      check_addr_log("wrap_addr");

      obs_addr.delete();
      beat_ready_i = 1'b0;
      aw(32'h2000, 8'd2, 3'd2, 2'b00, 4'h3, 1'b1);
      beat_ready_i = 1'b1;
      tick();
      beat_ready_i = 1'b0;
      repeat (3) tick();
      beat_ready_i = 1'b1;
      drain();
      exp_list = {32'h2000, 32'h2000, 32'h2000};
      check_addr_log("fixed_addr");

      obs_idx.delete();
      aw(32'h0100, 8'd1, 3'd2, 2'b01, 4'h1, 1'b0);
      aw(32'h0200, 8'd2, 3'd2, 2'b01, 4'h2, 1'b1);
      drain();
      exp_list = {32'd0, 32'd1, 32'd0, 32'd1, 32'd2};
      check_idx_log("b2b_idx");

      aw(32'h3000, 8'd7, 3'd2, 2'b01, 4'h7, 1'b0);
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      obs_addr.delete();
      aw(32'h4000, 8'd1, 3'd1, 2'b01, 4'h9, 1'b1);
      drain();
      exp_list = {32'h4000, 32'h4002};
      check_addr_log("post_rst_addr");

      obs_addr.delete();
      aw(32'h1006, 8'd2, 3'd1, 2'b10, 4'h4, 1'b0);
      drain();
      exp_list = {32'h1006, 32'h1008, 32'h100A};
      check_addr_log("wrap_len2_addr");

      obs_addr.delete();
      aw(32'h1038, 8'd3, 3'd3, 2'b11, 4'h4, 1'b0);
      drain();
      exp_list = {32'h1038, 32'h1040, 32'h1048, 32'h1050};
      check_addr_log("rsvd_addr");

      obs_addr.delete();
      aw(32'hFFFFFFFC, 8'd1, 3'd2, 2'b01, 4'h6, 1'b1);
      drain();
      exp_list = {32'hFFFFFFFC, 32'h00000000};
      check_addr_log("wrap_top_addr");

      rnd_mode = 1'b1;
      for (int i = 0; i < 200; i++) begin
         aw($urandom, 8'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 4'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end
      rnd_mode = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
